// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the RV32M divide issue controller: funct3 encodings, FSM states, result select.
package div_issue_ctrl_pkg;

   localparam int unsigned DFLT_XLEN      = 32;
   localparam int unsigned DFLT_REG_IDX_W = 5;

   typedef enum logic [2:0] {
      DIV  = 3'b100,
      DIVU = 3'b101,
      REM  = 3'b110,
      REMU = 3'b111
   } div_funct3_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } div_ctrl_state_t;

   function automatic logic [DFLT_XLEN-1:0] pick_result(input logic                 sel_rem,
                                                        input logic [DFLT_XLEN-1:0] q,
                                                        input logic [DFLT_XLEN-1:0] r);
      return sel_rem ? r : q;
   endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake between the divide issue controller (master) and the long-division divider (slave).
interface divider_if
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = DFLT_XLEN
);
   logic            div_en;
   logic [XLEN-1:0] div_a;
   logic [XLEN-1:0] div_b;
   logic            div_is_signed;
   logic [XLEN-1:0] div_q;
   logic [XLEN-1:0] div_r;
   logic            div_ready;
   logic            div_by_zero;
   logic            div_overflow;

   modport master (
      output div_en, div_a, div_b, div_is_signed,
      input  div_q, div_r, div_ready, div_by_zero, div_overflow
   );

   modport slave (
      input  div_en, div_a, div_b, div_is_signed,
      output div_q, div_r, div_ready, div_by_zero, div_overflow
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage front end for DIV/DIVU/REM/REMU: decodes, drives the divider, returns a tagged result.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN      = DFLT_XLEN,
   parameter int unsigned REG_IDX_W = DFLT_REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_funct3,
   input  logic [XLEN-1:0]      req_rs1,
   input  logic [XLEN-1:0]      req_rs2,
   input  logic [REG_IDX_W-1:0] req_rd,
   input  logic                 flush,
   output logic                 resp_valid,
   output logic [XLEN-1:0]      resp_data,
   output logic [REG_IDX_W-1:0] resp_rd,
   output logic [1:0]           resp_exc,
   divider_if.master            div
);

   div_ctrl_state_t state, state_nxt;

   logic                 req_is_div, req_signed, req_sel_rem;
   logic                 accept, hit, start, div_done;
   logic [XLEN-1:0]      op_a, op_b;
   logic                 op_signed, op_sel_rem, op_hit;
   logic [REG_IDX_W-1:0] op_rd;
   logic [XLEN-1:0]      cap_q, cap_r;
   logic [1:0]           cap_exc;

   assign req_is_div  = req_funct3[2];
   assign req_signed  = ~req_funct3[0];
   assign req_sel_rem = req_funct3[1];

   assign accept = (state == IDLE) && req_valid && !flush;
   assign start  = accept && req_is_div && !hit;
   // A cache hit still passes through WAIT for one cycle, completing on op_hit instead of div_ready.
   assign div_done = op_hit || div.div_ready;

`ifdef DIV_RESULT_CACHE_EN
   logic            c_valid, c_signed;
   logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r;
   logic [1:0]      c_exc;

   assign hit = c_valid && req_is_div && (c_rs1 == req_rs1) && (c_rs2 == req_rs2) &&
                (c_signed == req_signed);

   assign cap_q   = op_hit ? c_q   : div.div_q;
   assign cap_r   = op_hit ? c_r   : div.div_r;
   assign cap_exc = op_hit ? c_exc : {div.div_overflow, div.div_by_zero};

   always_ff @(posedge clk) begin
      if (nrst) begin
         c_valid  <= '0;
         c_signed <= '0;
         c_rs1    <= '0;
         c_rs2    <= '0;
         c_q      <= '0;
         c_r      <= '0;
         c_exc    <= '0;
      end else if (state == WAIT && !flush && div.div_ready && !op_hit) begin
         c_valid  <= '1;
         c_signed <= op_signed;
         c_rs1    <= op_a;
         c_rs2    <= op_b;
         c_q      <= div.div_q;
         c_r      <= div.div_r;
         c_exc    <= {div.div_overflow, div.div_by_zero};
      end
   end
`else
   assign hit     = '0;
   assign cap_q   = div.div_q;
   assign cap_r   = div.div_r;
   assign cap_exc = {div.div_overflow, div.div_by_zero};
`endif

   always_ff @(posedge clk) begin
      if (nrst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_is_div ? WAIT : RESP;
         // flush wins over a same-cycle completion; the divider cannot abort, so drain it otherwise
         WAIT:    if (flush)         state_nxt = div_done ? IDLE : DRAIN;
                  else if (div_done) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         DRAIN:   if (div.div_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready         = (state == IDLE);
      resp_valid        = (state == RESP) && !flush;
      div.div_en        = start;
      div.div_a         = start ? req_rs1    : op_a;
      div.div_b         = start ? req_rs2    : op_b;
      div.div_is_signed = start ? req_signed : op_signed;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         op_a       <= '0;
         op_b       <= '0;
         op_signed  <= '0;
         op_sel_rem <= '0;
         op_hit     <= '0;
         op_rd      <= '0;
         resp_data  <= '0;
         resp_rd    <= '0;
         resp_exc   <= '0;
      end else begin
         if (accept) begin
            op_a       <= req_rs1;
            op_b       <= req_rs2;
            op_signed  <= req_signed;
            op_sel_rem <= req_sel_rem;
            op_hit     <= hit;
            op_rd      <= req_rd;
         end
         if (accept && !req_is_div) begin
            resp_data <= '0;
            resp_exc  <= '0;
            resp_rd   <= req_rd;
         end
         if (state == WAIT && !flush && div_done) begin
            resp_data <= pick_result(op_sel_rem, cap_q, cap_r);
            resp_exc  <= cap_exc;
            resp_rd   <= op_rd;
         end
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a cycle-accurate behavioural long-division divider.
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        nrst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic [1:0]  resp_exc;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   divider_if #(.XLEN(32)) dif ();

   div_issue_ctrl #(.XLEN(32), .REG_IDX_W(5)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_exc   (resp_exc),
      .div        (dif)
   );

   // RV32M arithmetic rules
   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
   } qr_t;

   function automatic qr_t div_qr(input logic s, input logic [31:0] a, input logic [31:0] b);
      qr_t o;
      logic signed [31:0] sa, sb;
      sa = a; sb = b;
      o = '0;
      if (b == 32'd0) begin
         o.q = 32'hFFFF_FFFF; o.r = a; o.dbz = 1'b1;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         o.q = a; o.r = 32'd0; o.ovf = 1'b1;
      end else if (s) begin
         o.q = 32'(sa / sb); o.r = 32'(sa % sb);
      end else begin
         o.q = a / b; o.r = a % b;
      end
      return o;
   endfunction

   // Divider: PRECHECK answers special cases one cycle after start, otherwise 34 busy cycles
   logic [5:0] dv_cnt;
   qr_t        dv_res, dv_next;
   assign dv_next = div_qr(dif.div_is_signed, dif.div_a, dif.div_b);
   always_ff @(posedge clk) begin
      if (nrst) begin
         dv_cnt <= '0;
         dv_res <= '0;
      end else if (dif.div_en && dv_cnt == 6'd0) begin
         dv_res <= dv_next;
         dv_cnt <= (dv_next.dbz || dv_next.ovf) ? 6'd1 : 6'd34;
      end else if (dv_cnt != 6'd0) begin
         dv_cnt <= dv_cnt - 6'd1;
      end
   end
   assign dif.div_ready    = (dv_cnt == 6'd0);
   assign dif.div_q        = dv_res.q;
   assign dif.div_r        = dv_res.r;
   assign dif.div_by_zero  = dv_res.dbz;
   assign dif.div_overflow = dv_res.ovf;

   // Reference: result and latency from the instruction rules alone
   function automatic void ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic [1:0] e, output int lat);
      qr_t o;
      if (!f3[2]) begin
         d = 32'd0; e = 2'b00; lat = 1;
      end else begin
         o   = div_qr(!f3[0], a, b);
         d   = f3[1] ? o.r : o.q;
         e   = {o.ovf, o.dbz};
         lat = (o.dbz || o.ovf) ? 3 : 36;
      end
   endfunction

   // Last operand set the divider completed unflushed (only matters with the cache build)
   bit          mc_valid = 1'b0;
   logic [31:0] mc_a, mc_b;
   logic        mc_s;

   function automatic bit model_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_RESULT_CACHE_EN
      return f3[2] && mc_valid && mc_a == a && mc_b == b && mc_s == !f3[0];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_note(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_s = !f3[0];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_d,
                        input logic [1:0] exp_e, input int exp_lat_in);
      int exp_lat, lat, en_cnt;
      bit hit, uses_div, ready_bad, stab_bad;
      logic [31:0] d;
      logic [1:0]  e;
      logic [4:0]  r;
      hit      = model_hit(f3, a, b);
      exp_lat  = hit ? 2 : exp_lat_in;
      uses_div = f3[2] && !hit;
      lat = 0; en_cnt = 0; ready_bad = 0; stab_bad = 0; d = '0; e = '0; r = '0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
      @(negedge clk);
      chk({nm, ".ready_at_accept"}, req_ready, 1);
      if (dif.div_en) en_cnt++;
      if (uses_div) begin
         chk({nm, ".div_a_at_start"}, dif.div_a, a);
         chk({nm, ".signed_at_start"}, dif.div_is_signed, !f3[0]);
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_funct3 = 3'b000; req_rs1 = ~a; req_rs2 = ~b; req_rd = ~rd;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (dif.div_en) en_cnt++;
         if (resp_valid) begin
            lat = n; d = resp_data; e = resp_exc; r = resp_rd;
            break;
         end
         if (req_ready) ready_bad = 1'b1;
         if (uses_div && (dif.div_a !== a || dif.div_b !== b || dif.div_is_signed !== !f3[0]))
            stab_bad = 1'b1;
      end
      chk({nm, ".latency"}, lat, exp_lat);
      chk({nm, ".data"}, d, exp_d);
      chk({nm, ".exc"}, e, exp_e);
      chk({nm, ".rd"}, r, rd);
      chk({nm, ".div_en_pulses"}, en_cnt, uses_div ? 1 : 0);
      chk({nm, ".stall_held"}, ready_bad, 0);
      chk({nm, ".operands_stable"}, stab_bad, 0);
      @(negedge clk);
      chk({nm, ".resp_one_cycle"}, resp_valid, 0);
      chk({nm, ".ready_after_resp"}, req_ready, 1);
      if (uses_div) model_note(f3, a, b);
   endtask

   task automatic accept_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [1:0]  e;
      int          lat;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [13];
      logic [2:0]  f3;
      logic [31:0] a, b, d, pa, pb;
      logic [1:0]  e;
      int          lat, mode, first_dr, first_rr;
      bit          resp_seen, bad, rr;

      tbl[0]  = '{DIV,  32'd20,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFFA, 2'b00, 36};
      tbl[1]  = '{REMU, 32'd100,         32'd7,         5'd9,  32'd2,         2'b00, 36};
      tbl[2]  = '{DIVU, 32'd100,         32'd7,         5'd2,  32'd14,        2'b00, 36};
      tbl[3]  = '{DIVU, 32'd5,           32'd0,         5'd3,  32'hFFFF_FFFF, 2'b01, 3};
      tbl[4]  = '{REM,  32'd5,           32'd0,         5'd4,  32'd5,         2'b01, 3};
      tbl[5]  = '{DIV,  32'h8000_0000,   32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 2'b10, 3};
      tbl[6]  = '{REM,  32'h8000_0000,   32'hFFFF_FFFF, 5'd6,  32'd0,         2'b10, 3};
      tbl[7]  = '{DIVU, 32'h8000_0000,   32'hFFFF_FFFF, 5'd7,  32'd0,         2'b00, 36};
      tbl[8]  = '{REM,  32'hFFFF_FFF9,   32'd2,         5'd8,  32'hFFFF_FFFF, 2'b00, 36};
      tbl[9]  = '{DIV,  32'hFFFF_FFF9,   32'd2,         5'd10, 32'hFFFF_FFFD, 2'b00, 36};
      tbl[10] = '{3'b000, 32'd123,       32'd4,         5'd11, 32'd0,         2'b00, 1};
      tbl[11] = '{REMU, 32'd7,           32'hFFFF_FFFF, 5'd31, 32'd7,         2'b00, 36};
      tbl[12] = '{3'b011, 32'hDEAD_BEEF, 32'd0,         5'd0,  32'd0,         2'b00, 1};

      nrst = 1'b1; req_valid = 1'b0; flush = 1'b0;
      req_funct3 = 3'b000; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.req_ready", req_ready, 1);
      chk("reset.resp_valid", resp_valid, 0);
      chk("reset.resp_data", resp_data, 0);
      chk("reset.resp_rd", resp_rd, 0);
      chk("reset.resp_exc", resp_exc, 0);
      chk("reset.div_en", dif.div_en, 0);
      chk("reset.div_a", dif.div_a, 0);
      chk("reset.div_b", dif.div_b, 0);
      chk("reset.div_is_signed", dif.div_is_signed, 0);
      @(posedge clk); #1;
      nrst = 1'b0;

      for (int i = 0; i < 13; i++)
         do_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd,
               tbl[i].d, tbl[i].e, tbl[i].lat);

      // Flush ten cycles into a DIV: no response, ready returns the cycle after div_ready
      accept_op(DIV, 32'd1000, 32'd3, 5'd20);
      resp_seen = 0; first_dr = 0; first_rr = 0;
      for (int n = 1; n <= 45; n++) begin
         flush = (n == 10);
         @(negedge clk);
         if (resp_valid) resp_seen = 1'b1;
         if (dif.div_ready && first_dr == 0) first_dr = n;
         if (req_ready && first_rr == 0) first_rr = n;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("flush_wait.no_resp", resp_seen, 0);
      chk("flush_wait.ready_after_div_ready", first_rr, first_dr + 1);
      chk("flush_wait.ready_cycle", first_rr, 36);
      do_op("after_flush", DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 2'b00, 36);

      // Flush in IDLE blocks the same-cycle request
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = DIV; req_rs1 = 32'd123; req_rs2 = 32'd4; req_rd = 5'd1; flush = 1'b1;
      @(negedge clk);
      chk("flush_idle.div_en", dif.div_en, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid || !req_ready) bad = 1'b1;
      end
      chk("flush_idle.not_accepted", bad, 0);

      // Flush during RESP suppresses resp_valid
      accept_op(DIVU, 32'd77, 32'd0, 5'd22);
      resp_seen = 0; rr = 0;
      for (int n = 1; n <= 5; n++) begin
         flush = (n == 3);
         @(negedge clk);
         if (resp_valid) resp_seen = 1'b1;
         if (n == 4) rr = req_ready;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("flush_resp.no_resp", resp_seen, 0);
      chk("flush_resp.ready_next", rr, 1);
      model_note(DIVU, 32'd77, 32'd0);

      // Flush and div_ready in the same WAIT cycle go straight to IDLE
      accept_op(DIVU, 32'd11, 32'd0, 5'd23);
      resp_seen = 0; rr = 0;
      for (int n = 1; n <= 4; n++) begin
         flush = (n == 2);
         @(negedge clk);
         if (resp_valid) resp_seen = 1'b1;
         if (n == 3) rr = req_ready;
         @(posedge clk); #1;
      end
      flush = 1'b0;
      chk("flush_ready.no_resp", resp_seen, 0);
      chk("flush_ready.idle_next", rr, 1);

      // Reset in the middle of an operation
      accept_op(DIV, 32'd1000, 32'd7, 5'd24);
      repeat (5) @(posedge clk);
      #1 nrst = 1'b1;
      @(posedge clk); #1;
      nrst = 1'b0;
      @(negedge clk);
      chk("midreset.req_ready", req_ready, 1);
      chk("midreset.resp_data", resp_data, 0);
      chk("midreset.div_a", dif.div_a, 0);
      resp_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) resp_seen = 1'b1;
      end
      chk("midreset.no_resp", resp_seen, 0);
      mc_valid = 1'b0;

      // DIV+REM idiom on the same operands, then the unsigned variant
      do_op("idiom_div", DIV, 32'd50, 32'd7, 5'd12, 32'd7, 2'b00, 36);
      do_op("idiom_rem", REM, 32'd50, 32'd7, 5'd13, 32'd1, 2'b00, 36);
      do_op("idiom_remu", REMU, 32'd50, 32'd7, 5'd14, 32'd1, 2'b00, 36);

      pa = 32'd50; pb = 32'd7;
      for (int i = 0; i < 40; i++) begin
         f3 = ($urandom_range(0, 9) < 8) ? {1'b1, 2'($urandom_range(0, 3))} : 3'($urandom_range(0, 3));
         mode = $urandom_range(0, 5);
         case (mode)
            0:       begin a = $urandom; b = 32'd0; end
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       begin a = pa; b = pb; end
            3:       begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
            default: begin a = $urandom; b = $urandom; end
         endcase
         ref_op(f3, a, b, d, e, lat);
         do_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom_range(0, 31)), d, e, lat);
         pa = a; pb = b;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
